// File: rtl/note_source_merger_pkg.sv
// Shared definitions for the note source merger: FSM encoding, default note
// width and the fixed source-slot indices.
package note_source_merger_pkg;

  localparam int NOTE_W_DEFAULT = 10;

  localparam int SRC_SW   = 0;
  localparam int SRC_UART = 1;
  localparam int SRC_MEM  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2
  } merger_state_e;

endpackage

// File: rtl/note_rec_fifo.sv
// Recording FIFO for note changes. Sticky overflow flag; a push into a full
// FIFO succeeds only when a pop happens on the same edge.
module note_rec_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = valid && pop;
  assign do_push = push && (!full || do_pop);
  assign data    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !do_pop) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/note_source_merger.sv
// Merges note sources (OR or priority), rate-limits output changes with a hold
// FSM, and optionally records each change (macro NOTE_SOURCE_MERGER_REC_EN).
module note_source_merger
  import note_source_merger_pkg::*;
#(
  parameter int NOTE_W    = NOTE_W_DEFAULT,
  parameter int NUM_SRC   = 3,
  parameter int HOLD_CYC  = 4,
  parameter int REC_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*NOTE_W-1:0] src_notes,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic                      mode,
  output logic [NOTE_W-1:0]         note_out,
  output logic                      note_chg,
  output logic [NOTE_W-1:0]         rec_data,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic                      rec_ovf,
  output logic [1:0]                dbg_state
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

  merger_state_e     state;
  logic [7:0]        hold_cnt;
  logic [NOTE_W-1:0] merged;
  logic [NOTE_W-1:0] or_acc;
  logic [NOTE_W-1:0] pri_note;
  logic [NOTE_W-1:0] src_note;
  logic              pri_found;

  assign dbg_state = state;

  // Ascending scan: the first enabled non-zero source is the priority winner.
  always_comb begin
    or_acc    = '0;
    pri_note  = '0;
    pri_found = 1'b0;
    src_note  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_note = src_en[i] ? src_notes[i*NOTE_W +: NOTE_W] : '0;
      or_acc   = or_acc | src_note;
      if (!pri_found && (src_note != '0)) begin
        pri_note  = src_note;
        pri_found = 1'b1;
      end
    end
    merged = mode ? pri_note : or_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      note_out <= '0;
      note_chg <= 1'b0;
      hold_cnt <= '0;
    end else begin
      note_chg <= 1'b0;
      case (state)
        ST_IDLE, ST_PLAY: begin
          if (merged != note_out) begin
            note_out <= merged;
            note_chg <= 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Exit cycle performs no update; a pending change lands one cycle later.
          if (hold_cnt == '0) begin
            state <= (note_out == '0) ? ST_IDLE : ST_PLAY;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NOTE_SOURCE_MERGER_REC_EN
  note_rec_fifo #(
    .WIDTH (NOTE_W),
    .DEPTH (REC_DEPTH)
  ) u_rec_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (note_chg),
    .push_data (note_out),
    .pop       (rec_ready),
    .valid     (rec_valid),
    .data      (rec_data),
    .ovf       (rec_ovf)
  );
`else
  localparam int unused_rec_depth = REC_DEPTH;
  logic unused_rec_ready;
  assign unused_rec_ready = rec_ready;
  assign rec_valid = 1'b0;
  assign rec_data  = '0;
  assign rec_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_note_source_merger.sv
// Directed bench for note_source_merger: reset, merge modes, hold timing,
// glitch rejection and (with NOTE_SOURCE_MERGER_REC_EN) the recording FIFO.
module tb_note_source_merger;
  import note_source_merger_pkg::*;

  localparam int NOTE_W  = 10;
  localparam int NUM_SRC = 3;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC*NOTE_W-1:0] src_notes;
  logic [NUM_SRC-1:0]        src_en;
  logic                      mode;
  logic [NOTE_W-1:0]         note_out;
  logic                      note_chg;
  logic [NOTE_W-1:0]         rec_data;
  logic                      rec_valid;
  logic                      rec_ready;
  logic                      rec_ovf;
  logic [1:0]                dbg_state;

  int checks;
  int errors;
  int chg_cnt;
  int chg_base;
  logic [NOTE_W-1:0] exp_q[$];
  logic [NOTE_W-1:0] exp_v;

  note_source_merger #(
    .NOTE_W    (NOTE_W),
    .NUM_SRC   (NUM_SRC),
    .HOLD_CYC  (4),
    .REC_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_notes (src_notes),
    .src_en    (src_en),
    .mode      (mode),
    .note_out  (note_out),
    .note_chg  (note_chg),
    .rec_data  (rec_data),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_ovf   (rec_ovf),
    .dbg_state (dbg_state)
  );

  // Clock and pulse counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial chg_cnt = 0;
  always @(negedge clk) if (note_chg === 1'b1) chg_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_src(input logic [NOTE_W-1:0] s0, input logic [NOTE_W-1:0] s1,
                         input logic [NOTE_W-1:0] s2, input logic [2:0] en, input logic m);
    src_notes[SRC_SW*NOTE_W +: NOTE_W]   = s0;
    src_notes[SRC_UART*NOTE_W +: NOTE_W] = s1;
    src_notes[SRC_MEM*NOTE_W +: NOTE_W]  = s2;
    src_en = en;
    mode   = m;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Change applied in IDLE/PLAY: loads on the next edge, then wait out HOLD.
  task automatic apply(input string tag, input logic [NOTE_W-1:0] exp);
    tick();
    check(tag, 32'(note_out), 32'(exp));
    check({tag, "_chg"}, 32'(note_chg), 32'd1);
    tick(4);
  endtask

  task automatic do_reset();
    set_src('0, '0, '0, 3'b000, 1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rec_ready = 1'b1;
    src_notes = '0;
    set_src(10'h001, '0, '0, 3'b001, 1'b0);
    rst = 1'b1;
    tick(2);
    check("rst_note", 32'(note_out), 32'd0);
    check("rst_valid", 32'(rec_valid), 32'd0);
    check("rst_ovf", 32'(rec_ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chg_base = chg_cnt;
    rst = 1'b0;
    tick();
    check("first_note", 32'(note_out), 32'h001);
    check("first_chg", 32'(note_chg), 32'd1);
    check("first_state", 32'(dbg_state), 32'(ST_HOLD));
    tick(4);
    check("first_play", 32'(dbg_state), 32'(ST_PLAY));
    check("first_pulses", 32'(chg_cnt - chg_base), 32'd1);

    // Merge modes
    set_src(10'h001, 10'h004, '0, 3'b011, 1'b0);
    apply("mode_or", 10'h005);
    set_src(10'h001, 10'h004, '0, 3'b011, 1'b1);
    apply("mode_pri", 10'h001);
    set_src(10'h001, 10'h004, '0, 3'b010, 1'b1);
    apply("mode_pri_dis0", 10'h004);
    set_src(10'h001, 10'h004, '0, 3'b000, 1'b1);
    apply("mode_pri_none", 10'h000);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // Hold: 001 -> 002 -> 008 on consecutive cycles
    set_src(10'h001, '0, '0, 3'b001, 1'b0);
    chg_base = chg_cnt;
    tick();
    check("hold_c1", 32'(note_out), 32'h001);
    set_src(10'h002, '0, '0, 3'b001, 1'b0);
    tick();
    check("hold_c2", 32'(note_out), 32'h001);
    set_src(10'h008, '0, '0, 3'b001, 1'b0);
    tick();
    check("hold_c3", 32'(note_out), 32'h001);
    tick();
    check("hold_c4", 32'(note_out), 32'h001);
    check("hold_c4_state", 32'(dbg_state), 32'(ST_HOLD));
    tick();
    check("hold_c5", 32'(note_out), 32'h001);
    check("hold_c5_state", 32'(dbg_state), 32'(ST_PLAY));
    tick();
    check("hold_c6", 32'(note_out), 32'h008);
    check("hold_c6_chg", 32'(note_chg), 32'd1);
    tick(4);
    check("hold_pulses", 32'(chg_cnt - chg_base), 32'd2);

    // Glitch inside HOLD is ignored
    set_src(10'h001, '0, '0, 3'b001, 1'b0);
    chg_base = chg_cnt;
    tick();
    check("glitch_load", 32'(note_out), 32'h001);
    set_src(10'h010, '0, '0, 3'b001, 1'b0);
    tick(2);
    set_src(10'h001, '0, '0, 3'b001, 1'b0);
    tick(4);
    check("glitch_note", 32'(note_out), 32'h001);
    check("glitch_chg", 32'(note_chg), 32'd0);
    check("glitch_pulses", 32'(chg_cnt - chg_base), 32'd1);

`ifdef NOTE_SOURCE_MERGER_REC_EN
    // FIFO fill beyond depth with no reader
    rec_ready = 1'b0;
    do_reset();
    check("fifo_rst_valid", 32'(rec_valid), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      exp_v = NOTE_W'(1) << k;
      set_src(exp_v, '0, '0, 3'b001, 1'b0);
      tick(5);
      if (k < 8) exp_q.push_back(exp_v);
    end
    check("fifo_full_valid", 32'(rec_valid), 32'd1);
    check("fifo_full_ovf", 32'(rec_ovf), 32'd1);
    rec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_v = exp_q.pop_front();
      check("drain_valid", 32'(rec_valid), 32'd1);
      check("drain_data", 32'(rec_data), 32'(exp_v));
      tick();
    end
    check("drain_empty", 32'(rec_valid), 32'd0);
    check("drain_ovf_sticky", 32'(rec_ovf), 32'd1);

    // Full with simultaneous push and pop
    rec_ready = 1'b0;
    do_reset();
    check("sim_rst_ovf", 32'(rec_ovf), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      exp_v = NOTE_W'(1) << k;
      set_src(exp_v, '0, '0, 3'b001, 1'b0);
      tick(5);
      exp_q.push_back(exp_v);
    end
    check("sim_full_ovf", 32'(rec_ovf), 32'd0);
    check("sim_full_head", 32'(rec_data), 32'h001);
    set_src(10'h100, '0, '0, 3'b001, 1'b0);
    tick();
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(10'h100);
    check("sim_ovf_kept", 32'(rec_ovf), 32'd0);
    check("sim_head", 32'(rec_data), 32'h002);
    tick(3);
    set_src(10'h200, '0, '0, 3'b001, 1'b0);
    tick(5);
    check("sim_still_full", 32'(rec_ovf), 32'd1);
    rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      check("sim_drain", 32'(rec_data), 32'(exp_v));
      tick();
    end
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(rec_valid), 32'd0);
    check("mid_rst_data", 32'(rec_data), 32'd0);
    check("mid_rst_ovf", 32'(rec_ovf), 32'd0);
    rst = 1'b0;
`else
    rec_ready = 1'b0;
    set_src(10'h040, '0, '0, 3'b001, 1'b0);
    apply("norec_note", 10'h040);
    check("norec_valid", 32'(rec_valid), 32'd0);
    check("norec_data", 32'(rec_data), 32'd0);
    check("norec_ovf", 32'(rec_ovf), 32'd0);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
